// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing RV32I instructions through fetch/decode/execute/memory/writeback
module multicycle_controller #(
    parameter bit HAS_MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_ITYPE     = 1'b1,
    parameter bit SUPPORT_JAL       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic       MemReady,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp,
    output logic       Retire
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7,
        S_EXECI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10, S_HALT = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

    state_t r_state, w_next;
    logic   w_rdy, w_pcupdate, w_branch, w_irwrite, w_regwrite, w_memwrite, w_illegal, w_retire;

    assign w_rdy = HAS_MEM_HANDSHAKE ? MemReady : 1'b1;

    // state register; reset returns to FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // next-state and state-decoded controls, memory waits gated by rdy
    always_comb begin
        w_next     = r_state;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        w_retire   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_irwrite  = w_rdy;
                w_pcupdate = w_rdy;
                w_next     = w_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = SUPPORT_ITYPE ? S_EXECI : S_HALT;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = SUPPORT_JAL ? S_JAL : S_HALT;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = w_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = w_rdy;
                w_next     = w_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: w_illegal = 1'b1;
            default: w_next = S_HALT;
        endcase
    end

    // enables are held off for the whole time reset is asserted, not just after the edge
    assign PCUpdate  = w_pcupdate & rst_n;
    assign Branch    = w_branch & rst_n;
    assign IRWrite   = w_irwrite & rst_n;
    assign RegWrite  = w_regwrite & rst_n;
    assign MemWrite  = w_memwrite & rst_n;
    assign IllegalOp = w_illegal & rst_n;
    assign Retire    = w_retire & rst_n;
    assign State     = r_state;
    assign ImmSrc    = (Op == OP_SW) ? 2'b01 : (Op == OP_BEQ) ? 2'b10 : (Op == OP_JAL) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: vector table, corner sequences and random run against a phase-queue model
module tb_multicycle_controller;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                           BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    logic clk = 1'b0, rst_n = 1'b0, MemReady = 1'b1;
    logic [6:0] Op = LW, n_op = JL;
    logic PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, IllegalOp, Retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic [3:0] State;
    logic n_pc, n_br, n_ir, n_rw, n_mw, n_adr, n_ill, n_ret;
    logic [1:0] n_rs, n_a, n_b, n_imm, n_aop;
    logic [3:0] n_state;
    logic [15:0] w_o;
    logic [6:0] w_fl;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady), .PCUpdate(PCUpdate), .Branch(Branch),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .State(State),
        .IllegalOp(IllegalOp), .Retire(Retire)
    );

    multicycle_controller #(.HAS_MEM_HANDSHAKE(1'b0), .SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b0)) dut_min (
        .clk(clk), .rst_n(rst_n), .Op(n_op), .MemReady(1'b0), .PCUpdate(n_pc), .Branch(n_br),
        .IRWrite(n_ir), .RegWrite(n_rw), .MemWrite(n_mw), .AdrSrc(n_adr), .ResultSrc(n_rs),
        .ALUSrcA(n_a), .ALUSrcB(n_b), .ImmSrc(n_imm), .ALUOp(n_aop), .State(n_state),
        .IllegalOp(n_ill), .Retire(n_ret)
    );

    assign w_o  = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, IllegalOp, Retire};
    assign w_fl = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, Retire, IllegalOp};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // expected control word for a given state code, straight from the per-state output list
    function automatic logic [15:0] exp_out(input int code, input logic rdy);
        logic pc = 0, br = 0, ir = 0, rw = 0, mw = 0, adr = 0, ill = 0, ret = 0;
        logic [1:0] rs = 0, a = 0, b = 0, op = 0;
        case (code)
            0:  begin pc = rdy; ir = rdy; rs = 2; b = 2; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; ret = 1; end
            5:  begin adr = 1; mw = 1; ret = rdy; end
            6:  begin a = 2; op = 2; end
            7:  begin rw = 1; ret = 1; end
            8:  begin a = 2; b = 1; op = 2; end
            9:  begin a = 1; b = 2; pc = 1; end
            10: begin a = 2; op = 1; br = 1; ret = 1; end
            default: ill = 1;
        endcase
        return {pc, br, ir, rw, mw, adr, rs, a, b, op, ill, ret};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        return o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
    endfunction

    typedef struct packed {logic [6:0] op; logic rdy; logic [3:0] st; logic [6:0] fl;} vec_t;
    vec_t tv[$];
    task automatic add(input logic [6:0] o, input logic r, input logic [3:0] s, input logic [6:0] f);
        tv.push_back({o, r, s, f});
    endtask

    // model: current phase plus queue of remaining phases for the instruction in flight
    int cur = 0;
    int q[$];
    bit halted = 0;
    task automatic model_step(input logic [6:0] o, input logic rdy);
        if (halted) return;
        if ((cur == 0 || cur == 3 || cur == 5) && !rdy) return;
        if (cur == 0) begin cur = 1; return; end
        if (cur == 1) begin
            if (o == LW || o == SW) q = {2};
            else if (o == RT) q = {6, 7};
            else if (o == IT) q = {8, 7};
            else if (o == BQ) q = {10};
            else if (o == JL) q = {9, 7};
            else begin halted = 1; cur = 11; return; end
        end else if (cur == 2) q = (o == LW) ? {3, 4} : {5};
        cur = (q.size() != 0) ? q.pop_front() : 0;
    endtask

    initial begin
        add(LW,1,0,7'b1010000); add(LW,1,1,0); add(LW,1,2,0); add(LW,1,3,0); add(LW,1,4,7'b0001010);
        add(SW,1,0,7'b1010000); add(SW,1,1,0); add(SW,1,2,0);
        add(SW,0,5,7'b0000100); add(SW,0,5,7'b0000100); add(SW,0,5,7'b0000100); add(SW,1,5,7'b0000110);
        add(RT,1,0,7'b1010000); add(RT,1,1,0); add(RT,1,6,0); add(RT,1,7,7'b0001010);
        add(BQ,1,0,7'b1010000); add(BQ,1,1,0); add(BQ,1,10,7'b0100010);
        add(JL,1,0,7'b1010000); add(JL,1,1,0); add(JL,1,9,7'b1000000); add(JL,1,7,7'b0001010);
        add(RT,0,0,0); add(RT,0,0,0); add(RT,1,0,7'b1010000); add(RT,1,1,0); add(RT,1,6,0); add(RT,1,7,7'b0001010);
        add(BAD,1,0,7'b1010000); add(BAD,1,1,0); add(BAD,1,11,7'b0000001);
        add(LW,0,11,7'b0000001); add(SW,1,11,7'b0000001);

        repeat (2) @(negedge clk);
        #1 chk("reset_state", State, 0);
        chk("reset_flags", w_fl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tv[i]) begin
            Op = tv[i].op; MemReady = tv[i].rdy;
            #1 chk($sformatf("vec%0d_state", i), State, tv[i].st);
            chk($sformatf("vec%0d_flags", i), w_fl, tv[i].fl);
            chk($sformatf("vec%0d_outs", i), w_o, exp_out(tv[i].st, tv[i].rdy));
            chk($sformatf("vec%0d_imm", i), ImmSrc, exp_imm(tv[i].op));
            @(negedge clk);
        end

        #2 rst_n = 1'b0;
        #1 chk("halt_rst_state", State, 0);
        chk("halt_rst_illegal", IllegalOp, 0);
        @(negedge clk);
        rst_n = 1'b1; Op = SW; MemReady = 1'b1;
        repeat (3) @(negedge clk);
        MemReady = 1'b0;
        @(negedge clk);
        #1 chk("mw_before_rst", {State, MemWrite}, {4'd5, 1'b1});
        #2 rst_n = 1'b0;
        #1 chk("mw_async_drop", {State, MemWrite}, {4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b1; Op = RT;
        #1 chk("after_rst_fetch", {State, IRWrite, PCUpdate}, {4'd0, 2'b11});
        @(negedge clk);
        #1 chk("after_rst_decode", State, 1);

        @(negedge clk);
        rst_n = 1'b0; n_op = JL;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("min_fetch_nohs", {n_state, n_ir, n_pc}, {4'd0, 2'b11});
        @(negedge clk);
        #1 chk("min_decode", n_state, 1);
        @(negedge clk);
        #1 chk("min_jal_halt", {n_state, n_ill}, {4'd11, 1'b1});
        n_op = LW;
        @(negedge clk);
        #1 chk("min_halt_stays", {n_state, n_ill, n_ret}, {4'd11, 1'b1, 1'b0});
        rst_n = 1'b0; n_op = IT;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("min_itype_halt", {n_state, n_ill}, {4'd11, 1'b1});

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cur = 0; q.delete(); halted = 0;
        for (int k = 0; k < 1500; k++) begin
            if (halted && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                cur = 0; q.delete(); halted = 0;
            end
            begin
                logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
                int idx = $urandom_range(0, 12);
                Op = (idx < 12) ? ops[idx % 6] : 7'($urandom);
            end
            MemReady = ($urandom_range(0, 3) != 0);
            #1 chk("rnd_state", State, cur);
            chk("rnd_outs", w_o, exp_out(cur, MemReady));
            chk("rnd_imm", ImmSrc, exp_imm(Op));
            model_step(Op, MemReady);
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM for the multicycle RV32I core; next generation of the single-cycle main decoder.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback cycles.
- Drives the shared-memory, ALU-mux and register-file enables.
- Adds a memory-ready handshake, optional I-type and JAL support, an illegal-opcode halt, and an instruction-retire pulse.

Parameters:
- HAS_MEM_HANDSHAKE, 1: 1 = Fetch/MemRead/MemWrite wait for MemReady; 0 = MemReady ignored and treated as 1.
- SUPPORT_ITYPE, 1: 1 = opcode 0010011 is legal; 0 = it is illegal.
- SUPPORT_JAL, 1: 1 = opcode 1101111 is legal; 0 = it is illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  7  opcode from the instruction register, valid from Decode onward
- MemReady  in  1  unified memory has completed the current access this cycle
- PCUpdate  out  1  unconditional PC write enable
- Branch  out  1  conditional PC write; datapath ANDs it with Zero
- IRWrite  out  1  instruction register and OldPC write enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write strobe
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  combinational from Op: lw/I-type 00, sw 01, beq 10, jal 11, others 00
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- State  out  4  current state code, for debug
- IllegalOp  out  1  high while in HALT
- Retire  out  1  one-cycle pulse in the final cycle of every instruction

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, HALT 11. Codes 12-15 go to HALT on the next edge.
- Reset:
  - rst_n low asynchronously forces State = FETCH.
  - While rst_n is low, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, Retire and IllegalOp are forced to 0.
  - The first active edge after release is a FETCH cycle.
- Default output values, used wherever a state does not name an output: all enables 0, AdrSrc 0, all 2-bit selects 00.
- Handshake gating: "rdy" means MemReady, or 1 when HAS_MEM_HANDSHAKE = 0.
- Per-state outputs and transitions:
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10. IRWrite and PCUpdate equal rdy. Next state is DECODE if rdy, else stay in FETCH.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (precomputes the branch target). Next state by Op:
    - lw or sw -> MEMADR
    - R-type 0110011 -> EXECR
    - I-type -> EXECI if SUPPORT_ITYPE
    - beq 1100011 -> BEQ
    - jal -> JAL if SUPPORT_JAL
    - anything else -> HALT
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Next is MEMREAD if Op = 0000011, else MEMWRITE.
  - MEMREAD: AdrSrc 1, ResultSrc 00. Next is MEMWB if rdy, else stay.
  - MEMWB: ResultSrc 01, RegWrite 1, Retire 1. Next is FETCH.
  - MEMWRITE: AdrSrc 1, ResultSrc 00. MemWrite is held high until and including the rdy cycle. Retire equals rdy. Next is FETCH if rdy, else stay.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Next is ALUWB.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Next is ALUWB.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1. Next is ALUWB.
  - ALUWB: ResultSrc 00, RegWrite 1, Retire 1. Next is FETCH.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1, Retire 1. Next is FETCH.
  - HALT: all enables 0, IllegalOp 1. Stays in HALT until reset.
- Cycle counts with MemReady tied high:
  - lw 5 cycles
  - sw 4 cycles
  - R-type, I-type and jal 4 cycles
  - beq 3 cycles
  - Each low cycle of MemReady in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Op is sampled only in DECODE and MEMADR; changes of Op in other states have no effect.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- All outputs except ImmSrc are decoded from the registered state, plus rdy gating where stated above. No output depends on Op except ImmSrc.

Test Plan:
- Reset, then Op = 0000011 (lw) with MemReady = 1: State sequence 0, 1, 2, 3, 4, 0. IRWrite and PCUpdate high in cycle 0; RegWrite and Retire high in the MEMWB cycle only; cycle-5 ResultSrc = 01.
- sw (0100011) with MemReady low for 3 cycles in MEMWRITE: MemWrite high for 4 consecutive cycles, a single Retire pulse on the 4th, then FETCH. ImmSrc = 01 throughout.
- R-type 0110011, then beq 1100011, then jal 1101111, with MemReady = 1:
  - R-type: states 0, 1, 6, 7.
  - beq: states 0, 1, 10 with Branch = 1 and ALUOp = 01.
  - jal: states 0, 1, 9, 7 with PCUpdate = 1 in JAL.
  - Exactly 3 Retire pulses in total.
- MemReady low for 2 cycles in FETCH: IRWrite and PCUpdate stay 0 for 2 cycles, then pulse for 1 cycle; DECODE follows.
- SUPPORT_JAL = 0 with Op = 1101111, or Op = 1111111 in the default configuration: DECODE goes to HALT and IllegalOp stays 1 regardless of Op/MemReady. Asserting rst_n low mid-HALT immediately gives State = 0 and IllegalOp = 0.
- rst_n asserted asynchronously mid-MEMWRITE: MemWrite drops to 0 without waiting for a clock edge; after release the next instruction begins in FETCH.
